// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locking arbiter feeding the write port of the result FIFO.
// One word is buffered in a registered output stage; wfull back-pressures the requesters.
module fifo_write_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DSIZE = 8,
  parameter int unsigned BURST = 4
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DSIZE-1:0]     req_data,
  output logic [NREQ-1:0]           req_ack,
  output logic                      winc,
  output logic [DSIZE-1:0]          wdata,
  input  logic                      wfull,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(BURST + 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(BURST);
  localparam logic [IdW:0]    NreqW    = (IdW + 1)'(NREQ);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    owner_q, owner_d;
  logic [CntW-1:0]   bcnt_q, bcnt_d;
  logic              winc_q, winc_d;
  logic [DSIZE-1:0]  wdata_q, wdata_d;
  logic [IdW-1:0]    gid_q, gid_d;

  logic              accept, can_load, load, keep;
  logic [IdW-1:0]    rr_sel, sel;
  logic [IdW:0]      rr_idx;
  logic              rr_found;
  logic [DSIZE-1:0]  sel_data;

  assign accept   = winc_q & ~wfull;
  assign can_load = ~winc_q | accept;
  assign load     = can_load & (|req);

  // First requester after the current owner, wrapping back to the owner itself last.
  always_comb begin
    rr_sel   = owner_q;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      rr_idx = {1'b0, owner_q} + (IdW + 1)'(k);
      if (rr_idx >= NreqW) rr_idx = rr_idx - NreqW;
      if (!rr_found && req[rr_idx[IdW-1:0]]) begin
        rr_sel   = rr_idx[IdW-1:0];
        rr_found = 1'b1;
      end
    end
  end

  assign keep = (state_q == StLocked) && req[owner_q] && (bcnt_q < BurstMax);
  assign sel  = keep ? owner_q : rr_sel;

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel == IdW'(i)) sel_data = req_data[i*DSIZE +: DSIZE];
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= StIdle;
      owner_q <= IdW'(NREQ - 1);
      bcnt_q  <= '0;
      winc_q  <= 1'b0;
      wdata_q <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      bcnt_q  <= bcnt_d;
      winc_q  <= winc_d;
      wdata_q <= wdata_d;
      gid_q   <= gid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          owner_d = sel;
          bcnt_d  = CntW'(1);
          state_d = (BURST > 1) ? StLocked : StIdle;
        end
      end
      StLocked: begin
        if (load) begin
          if (keep) begin
            bcnt_d = bcnt_q + CntW'(1);
          end else begin
            owner_d = sel;
            bcnt_d  = CntW'(1);
          end
        end
        if (can_load && !req[owner_q]) begin
          state_d = StIdle;
        end else if (!load && (bcnt_q == BurstMax)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output stage: a load may replace the word being accepted in the same cycle.
  always_comb begin
    winc_d  = winc_q;
    wdata_d = wdata_q;
    gid_d   = gid_q;
    if (load) begin
      winc_d  = 1'b1;
      wdata_d = sel_data;
      gid_d   = sel;
    end else if (accept) begin
      winc_d  = 1'b0;
    end
  end

  always_comb begin
    req_ack = '0;
    if (load && wrst_n) req_ack[sel] = 1'b1;
    busy     = (state_q == StLocked);
    winc     = winc_q;
    wdata    = wdata_q;
    grant_id = gid_q;
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: per-cycle vector table plus a scoreboard of words
// expected at the FIFO write port, and hand sequences for reset and BURST=1.
module tb_fifo_write_arbiter;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic        winc;
  logic [7:0]  wdata;
  logic        wfull;
  logic [1:0]  grant_id;
  logic        busy;

  logic [3:0]  req_b1;
  logic [31:0] req_data_b1;
  logic [3:0]  req_ack_b1;
  logic        winc_b1;
  logic [7:0]  wdata_b1;
  logic [1:0]  grant_id_b1;
  logic        busy_b1;

  always #5 wclk = ~wclk;

  fifo_write_arbiter #(.NREQ(4), .DSIZE(8), .BURST(4)) u_dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .req      (req),
    .req_data (req_data),
    .req_ack  (req_ack),
    .winc     (winc),
    .wdata    (wdata),
    .wfull    (wfull),
    .grant_id (grant_id),
    .busy     (busy)
  );

  fifo_write_arbiter #(.NREQ(4), .DSIZE(8), .BURST(1)) u_dut_b1 (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .req      (req_b1),
    .req_data (req_data_b1),
    .req_ack  (req_ack_b1),
    .winc     (winc_b1),
    .wdata    (wdata_b1),
    .wfull    (wfull),
    .grant_id (grant_id_b1),
    .busy     (busy_b1)
  );

  typedef struct {
    bit         rst;
    int         tag;
    logic [3:0] req;
    logic       wfull;
    logic [3:0] ack;
    logic       winc;
    logic [1:0] gid;
    logic       busy;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb[$];
  int         cnt[4];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] word(input int i);
    return 8'(((i + 1) << 4) | (cnt[i] & 15));
  endfunction

  function automatic void add(input bit rst, input int tag, input logic [3:0] rq,
                              input logic wf, input logic [3:0] ak, input logic wi,
                              input logic [1:0] gd, input logic bz);
    vec_t v;
    v.rst = rst; v.tag = tag; v.req = rq; v.wfull = wf;
    v.ack = ak; v.winc = wi; v.gid = gd; v.busy = bz;
    tbl.push_back(v);
  endfunction

  // Entered and left at posedge+1.
  task automatic do_reset();
    chk("scoreboard drained", sb.size(), 0);
    wrst_n = 1'b0;
    req    = '0;
    req_b1 = '0;
    wfull  = 1'b0;
    #1;
    chk("reset winc", winc, 0);
    chk("reset wdata", wdata, 0);
    chk("reset grant_id", grant_id, 0);
    chk("reset busy", busy, 0);
    chk("reset winc b1", winc_b1, 0);
    sb.delete();
    @(negedge wclk);
    wrst_n = 1'b1;
    @(posedge wclk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int k);
    string nm;
    req   = v.req;
    wfull = v.wfull;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = word(i);
    #1;
    nm = $sformatf("t%0d.v%0d", v.tag, k);
    chk({nm, " req_ack"}, req_ack, v.ack);
    chk({nm, " winc"}, winc, v.winc);
    chk({nm, " grant_id"}, grant_id, v.gid);
    chk({nm, " busy"}, busy, v.busy);
    if (v.winc) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s wdata: got %0h, expected no word in stage", nm, wdata);
      end else begin
        chk({nm, " wdata"}, wdata, sb[0]);
        if (!v.wfull) void'(sb.pop_front());
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (v.ack[i]) begin
        sb.push_back(word(i));
        cnt[i]++;
      end
    end
    @(posedge wclk);
    #1;
  endtask

  initial begin
    wrst_n      = 1'b0;
    req         = '0;
    req_b1      = '0;
    wfull       = 1'b0;
    req_data    = '0;
    req_data_b1 = 32'h4D3C2B1A;
    for (int i = 0; i < 4; i++) cnt[i] = 0;

    // Single requester, three words.
    add(1, 1, 4'b0001, 0, 4'b0001, 0, 0, 0);
    add(0, 1, 4'b0001, 0, 4'b0001, 1, 0, 1);
    add(0, 1, 4'b0001, 0, 4'b0001, 1, 0, 1);
    add(0, 1, 4'b0000, 0, 4'b0000, 1, 0, 1);
    add(0, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    // All four continuous: bursts of four, rotating.
    for (int c = 0; c < 17; c++) begin
      add(c == 0, 2, 4'b1111, 0, 4'(1 << ((c / 4) % 4)), c > 0,
          (c == 0) ? 2'd0 : 2'(((c - 1) / 4) % 4), c > 0);
    end
    add(0, 2, 4'b0000, 0, 4'b0000, 1, 0, 1);
    add(0, 2, 4'b0000, 0, 4'b0000, 0, 0, 0);
    // wfull held for five cycles with a word in the stage.
    add(1, 3, 4'b0001, 0, 4'b0001, 0, 0, 0);
    for (int c = 0; c < 5; c++) add(0, 3, 4'b0001, 1, 4'b0000, 1, 0, 1);
    add(0, 3, 4'b0001, 0, 4'b0001, 1, 0, 1);
    add(0, 3, 4'b0000, 0, 4'b0000, 1, 0, 1);
    add(0, 3, 4'b0000, 0, 4'b0000, 0, 0, 0);
    // Owner drops mid-burst while requester 2 waits.
    add(1, 4, 4'b0001, 0, 4'b0001, 0, 0, 0);
    add(0, 4, 4'b0101, 0, 4'b0001, 1, 0, 1);
    add(0, 4, 4'b0100, 0, 4'b0100, 1, 0, 1);
    add(0, 4, 4'b0100, 0, 4'b0100, 1, 2, 0);
    add(0, 4, 4'b0100, 0, 4'b0100, 1, 2, 1);
    add(0, 4, 4'b0000, 0, 4'b0000, 1, 2, 1);
    add(0, 4, 4'b0000, 0, 4'b0000, 0, 2, 0);

    @(posedge wclk);
    #1;
    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].rst) do_reset();
      apply(tbl[k], k);
    end

    // Reset asserted mid-operation with a word held in the stage.
    do_reset();
    add(0, 5, 4'b0100, 0, 4'b0100, 0, 0, 0);
    add(0, 5, 4'b0100, 0, 4'b0100, 1, 2, 1);
    apply(tbl[tbl.size() - 2], 0);
    apply(tbl[tbl.size() - 1], 1);
    wrst_n = 1'b0;
    #1;
    chk("midrst winc", winc, 0);
    chk("midrst wdata", wdata, 0);
    chk("midrst busy", busy, 0);
    chk("midrst grant_id", grant_id, 0);
    chk("midrst req_ack", req_ack, 0);
    req = '0;
    sb.delete();
    @(negedge wclk);
    wrst_n = 1'b1;
    @(posedge wclk);
    #1;
    add(0, 5, 4'b1111, 0, 4'b0001, 0, 0, 0);
    add(0, 5, 4'b0000, 0, 4'b0000, 1, 0, 1);
    add(0, 5, 4'b0000, 0, 4'b0000, 0, 0, 0);
    for (int k = tbl.size() - 3; k < tbl.size(); k++) apply(tbl[k], k);

    // BURST=1 instance, requesters 1 and 3 continuous.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_b1 = 4'b1010;
      #1;
      chk($sformatf("b1.c%0d req_ack", c), req_ack_b1, (c % 2 == 0) ? 4'b0010 : 4'b1000);
      chk($sformatf("b1.c%0d busy", c), busy_b1, 0);
      if (c > 0) begin
        chk($sformatf("b1.c%0d winc", c), winc_b1, 1);
        chk($sformatf("b1.c%0d grant_id", c), grant_id_b1, (c % 2 == 1) ? 2'd1 : 2'd3);
        chk($sformatf("b1.c%0d wdata", c), wdata_b1, (c % 2 == 1) ? 8'h2B : 8'h4D);
      end
      @(posedge wclk);
      #1;
    end
    req_b1 = '0;
    @(posedge wclk);
    #1;
    chk("b1 drain winc", winc_b1, 0);
    chk("scoreboard drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
